// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the architectural PC, issues one fetch at a time
// and hands each instruction to decode through a one-entry valid/ready buffer.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] DROP = 3'd3;
    localparam logic [2:0] HOLD = 3'd4;

    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] tgt;

    assign tgt       = redirect_pc & 32'hFFFF_FFFC;
    assign imem_req  = (state == REQ) & ~redirect_valid;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inst_valid  <= 1'b0;
            inst        <= 32'h0;
            inst_pc     <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) pc <= tgt;
                    state <= REQ;
                end
                REQ: begin
                    if (redirect_valid) pc <= tgt;
                    else                state <= WAIT;
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc    <= tgt;
                        state <= imem_rvalid ? REQ : DROP;
                    end else if (imem_rvalid) begin
                        inst       <= imem_rdata;
                        inst_pc    <= pc;
                        pc         <= pc + 32'd4;
                        inst_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                // stale response still owed by memory; swallow it
                DROP: begin
                    if (redirect_valid) pc <= tgt;
                    if (imem_rvalid)    state <= REQ;
                end
                HOLD: begin
                    if (inst_ready)     fetch_count <= fetch_count + 32'd1;
                    if (redirect_valid) pc <= tgt;
                    if (inst_ready || redirect_valid) begin
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: latency-table vectors plus redirect/reset sequences,
// with a scoreboard of expected {inst, inst_pc} filled at response time.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;

    fetch_sequencer dut (
        .clk(clk), .rstn(rstn),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        int          lat;
        int          stall;
        logic [31:0] data;
        int          gap;
    } vec_t;

    int checks = 0;
    int failures = 0;

    exp_t        sb[$];
    int          hs_cyc[$];
    int          lat = 1, stall = 0, cnt = 0, hold_cnt = 0;
    int          cyc = 0, hs_total = 0, nreq = 0;
    logic        fixed_en = 1'b0, force_en = 1'b0, force_rdy = 1'b0;
    logic        pend = 1'b0, stale = 1'b0, inject = 1'b0;
    logic        last_req = 1'b0;
    logic        prev_valid = 1'b0, prev_used = 1'b0;
    logic [31:0] fixed_data = 32'h0, paddr = 32'h0, exp_pc = 32'h0;
    logic [31:0] exp_cnt = 32'h0, last_addr = 32'h0, last_hs_pc = 32'h0;
    logic [31:0] prev_inst = 32'h0, prev_pc = 32'h0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    function automatic logic [31:0] mem_fn(logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic clear_model();
        pend = 1'b0; stale = 1'b0; inject = 1'b0;
        sb.delete();
        exp_pc = 32'h0; exp_cnt = 32'h0;
        hold_cnt = 0; prev_valid = 1'b0; prev_used = 1'b0;
    endtask

    // one clock: called at edge+1, returns at next edge+1
    task automatic cycle();
        logic        resp;
        logic [31:0] rd;
        logic        hs;
        exp_t        e;
        chk("fetch_count", fetch_count, exp_cnt);
        if (prev_valid && !prev_used) begin
            chk1("valid_held", inst_valid, 1'b1);
            chk("inst_stable", inst, prev_inst);
            chk("inst_pc_stable", inst_pc, prev_pc);
        end
        resp = 1'b0;
        rd = 32'h0;
        if (inject) begin
            resp = 1'b1;
            rd = 32'hDEADBEEF;
        end else if (pend) begin
            if (cnt <= 1) begin
                resp = 1'b1;
                pend = 1'b0;
                rd = stale ? 32'hDEADBEEF :
                     fixed_en ? fixed_data : mem_fn(paddr);
                if (!stale && !redirect_valid) begin
                    sb.push_back('{rd, paddr});
                    exp_pc = paddr + 32'd4;
                end
                stale = 1'b0;
            end else begin
                cnt--;
            end
        end
        imem_rvalid = resp;
        imem_rdata = rd;
        if (redirect_valid) begin
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
            if (pend) stale = 1'b1;
        end
        if (force_en) inst_ready = force_rdy;
        else inst_ready = inst_valid && (hold_cnt >= stall);
        hold_cnt = inst_valid ? hold_cnt + 1 : 0;
        #1;
        last_req = imem_req;
        last_addr = imem_addr;
        if (imem_req) begin
            chk("req_addr", imem_addr, exp_pc);
            chk1("one_outstanding", pend, 1'b0);
            chk1("req_in_hold", inst_valid, 1'b0);
            pend = 1'b1;
            cnt = lat;
            paddr = imem_addr;
            nreq++;
        end
        hs = inst_valid && inst_ready;
        if (hs) begin
            if (sb.size() == 0) begin
                chk1("unexpected_inst", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("inst", inst, e.data);
                chk("inst_pc", inst_pc, e.pc);
            end
            exp_cnt = exp_cnt + 32'd1;
            hs_total++;
            hs_cyc.push_back(cyc);
            last_hs_pc = inst_pc;
        end else if (inst_valid && redirect_valid) begin
            if (sb.size() > 0) void'(sb.pop_front());
        end
        prev_valid = inst_valid;
        prev_used = hs || redirect_valid;
        prev_inst = inst;
        prev_pc = inst_pc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_hs(int n);
        int h0;
        h0 = hs_total;
        for (int i = 0; i < 400 && hs_total < h0 + n; i++) cycle();
        chk("hs_budget", 32'(hs_total - h0), 32'(n));
    endtask

    task automatic wait_req();
        last_req = 1'b0;
        for (int i = 0; i < 100 && !last_req; i++) cycle();
        chk1("req_budget", last_req, 1'b1);
    endtask

    task automatic wait_valid();
        int i;
        for (i = 0; i < 100 && !inst_valid; i++) cycle();
        chk1("valid_budget", inst_valid, 1'b1);
    endtask

    initial begin
        vec_t        vt[5];
        int          k, n0;
        logic [31:0] c0;

        vt[0] = '{1, 0, 32'h0000_0013, 3};
        vt[1] = '{4, 5, 32'hCAFE_0001, 11};
        vt[2] = '{2, 1, 32'h00A0_0093, 5};
        vt[3] = '{3, 0, 32'h0010_0073, 5};
        vt[4] = '{1, 3, 32'h1234_5678, 6};

        rstn = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        clear_model();
        #2;
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk1("idle_req", imem_req, 1'b0);

        for (int v = 0; v < 5; v++) begin
            lat = vt[v].lat;
            stall = vt[v].stall;
            fixed_en = 1'b1;
            fixed_data = vt[v].data;
            k = hs_cyc.size();
            n0 = nreq;
            run_hs(3);
            chk("gap_a", 32'(hs_cyc[k + 1] - hs_cyc[k]), 32'(vt[v].gap));
            chk("gap_b", 32'(hs_cyc[k + 2] - hs_cyc[k + 1]), 32'(vt[v].gap));
            chk("req_per_fetch", 32'(nreq - n0), 32'd3);
            if (v == 0) begin
                chk("first_count", fetch_count, 32'd3);
                chk("first_pc", last_hs_pc, 32'h8);
            end
        end

        // redirect during WAIT, stale data 2 cycles later
        fixed_en = 1'b0;
        lat = 3;
        stall = 0;
        wait_req();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        redirect_valid = 1'b0;
        wait_req();
        chk("wait_redir_addr", last_addr, 32'h100);
        run_hs(1);
        chk("wait_redir_pc", last_hs_pc, 32'h100);

        // redirect coincident with rvalid: straight back to REQ
        lat = 2;
        wait_req();
        for (int i = 0; i < 20 && !(pend && cnt <= 1); i++) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk1("same_redir_req", last_req, 1'b1);
        chk("same_redir_addr", last_addr, 32'h200);
        run_hs(1);
        chk("same_redir_pc", last_hs_pc, 32'h200);

        // HOLD with redirect and ready together, then redirect alone
        stall = 100;
        wait_valid();
        c0 = fetch_count;
        force_en = 1'b1; force_rdy = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        cycle();
        redirect_valid = 1'b0; force_en = 1'b0;
        chk("hold_both_count", fetch_count, c0 + 32'd1);
        wait_req();
        chk("hold_both_addr", last_addr, 32'h300);
        wait_valid();
        c0 = fetch_count;
        force_en = 1'b1; force_rdy = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        cycle();
        redirect_valid = 1'b0; force_en = 1'b0;
        chk("hold_redir_count", fetch_count, c0);
        wait_req();
        chk("hold_redir_addr", last_addr, 32'h400);
        stall = 0;
        run_hs(1);
        chk("hold_redir_pc", last_hs_pc, 32'h400);

        // PC wrap at top of address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        run_hs(1);
        chk("wrap_pc", last_hs_pc, 32'hFFFF_FFFC);
        wait_req();
        chk("wrap_addr", last_addr, 32'h0);

        // async reset while in WAIT; late response must be ignored
        rstn = 1'b0;
        #1;
        chk1("arst_valid", inst_valid, 1'b0);
        chk("arst_inst", inst, 32'h0);
        chk("arst_inst_pc", inst_pc, 32'h0);
        chk("arst_count", fetch_count, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        chk1("arst_req", imem_req, 1'b0);
        #1;
        rstn = 1'b1;
        clear_model();
        inject = 1'b1;
        cycle();
        cycle();
        inject = 1'b0;
        run_hs(2);
        chk("post_rst_pc", last_hs_pc, 32'h4);
        chk("post_rst_count", fetch_count, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch from instruction memory, one outstanding request at a time.
- Delivers fetched instructions downstream over a valid/ready handshake.
- Accepts redirects from the next-PC selection logic: taken branch, JAL, JALR.
- Sits between instruction memory and decode. It is the sequential owner of the value that next-PC selection computes.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- imem_req  out  1  one-cycle fetch request strobe
- imem_addr  out  32  fetch address; equals pc
- imem_rvalid  in  1  read data valid; ≥1 cycle after imem_req
- imem_rdata  in  32  instruction word
- inst_valid  out  1  buffered instruction available
- inst_ready  in  1  decode accepts instruction
- inst  out  32  buffered instruction
- inst_pc  out  32  address of buffered instruction
- redirect_valid  in  1  replace PC (branch taken/JAL/JALR)
- redirect_pc  in  32  new PC target
- fetch_count  out  32  completed inst handshakes, wraps

Behaviour:
- Clock and reset
  - One clock. Reset is asynchronous and active-low; all flops are async-cleared on rstn=0.
- Reset values
  - state=IDLE, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_count=0.
  - imem_req=0 while in IDLE.
- States
  - IDLE: lasts 1 cycle after reset deassertion, then → REQ. A redirect in IDLE loads pc and still → REQ.
  - REQ
    - imem_req = (state==REQ) & ~redirect_valid, combinational.
    - imem_addr = pc at all times.
    - If imem_req=1 → WAIT.
    - If redirect_valid=1: pc ← {redirect_pc[31:2],2'b00}, no request issued, stay in REQ.
  - WAIT: awaiting imem_rvalid.
    - rvalid & ~redirect: inst ← imem_rdata, inst_pc ← pc, pc ← pc+4 (mod 2^32), inst_valid ← 1, → HOLD.
    - redirect & rvalid in the same cycle: data discarded, pc ← redirect target, → REQ.
    - redirect & ~rvalid: pc ← redirect target, → DROP.
  - DROP: awaiting the stale response.
    - On rvalid: discard data, → REQ.
    - Further redirects in DROP update pc; state stays DROP until rvalid.
  - HOLD: inst_valid=1; inst and inst_pc held stable.
    - inst_ready=1: handshake completes, fetch_count += 1, inst_valid ← 0, → REQ.
    - redirect_valid=1 with inst_ready=1: the handshake still counts. pc ← redirect target, inst_valid ← 0, → REQ.
    - redirect_valid=1 without inst_ready: buffered instruction dropped without counting, inst_valid ← 0, pc ← target, → REQ.
- Timing and constraints
  - Minimum fetch period: REQ→WAIT→HOLD→REQ is 3 cycles, with a 1-cycle memory and ready asserted.
  - inst_valid is never asserted outside HOLD.
  - inst_valid never falls without a handshake or redirect.
  - imem_rvalid outside WAIT/DROP is ignored.
  - redirect_pc[1:0] is ignored (forced 0).
  - pc+4 wraps 32'hFFFF_FFFC → 0.
  - fetch_count wraps 32'hFFFF_FFFF → 0.
- Reset mid-operation
  - rstn asserted in any state returns immediately to the reset values.
  - A response still in flight after reset is ignored: IDLE and REQ do not sample rvalid.

Test Plan:
- Reset release, 1-cycle memory returning 32'h00000013, ready=1 → imem_req pulses at addr 0, 4, 8. inst_pc sequence 0, 4, 8. One handshake every 3 cycles. fetch_count=3 after the third.
- Memory latency 4 cycles, ready held 0 for 5 cycles in HOLD → exactly one imem_req per fetch. inst and inst_pc stable while stalled. No request issued during HOLD.
- Redirect to 32'h0000_0100 during WAIT, stale rvalid 2 cycles later with 32'hDEADBEEF → data never appears on inst. Next imem_addr=32'h100. First delivered inst_pc=32'h100.
- Redirect to 32'h0000_0203 in the same cycle as rvalid → data discarded. Next imem_addr=32'h200. No DROP state entered.
- HOLD with redirect_valid & inst_ready both 1 → fetch_count increments. Next fetch at the redirect target. HOLD with redirect only → count unchanged.
- PC at 32'hFFFF_FFFC fetched → next imem_addr=0. rstn pulsed low while in WAIT → outputs return to reset values asynchronously, and a late rvalid is ignored.
